// File: rtl/cbus_pkg.sv
// Common CBus header: request/response bundles shared by initiators and responders.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_sram_responder_pkg.sv
// Burst encodings and FSM states for the CBus SRAM responder.
package cbus_sram_responder_pkg;

    localparam logic [1:0] CBUS_BURST_FIXED = 2'd0;
    localparam logic [1:0] CBUS_BURST_INCR  = 2'd1;
    localparam logic [1:0] CBUS_BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } cbus_sram_state_t;

    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) ||
               (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/cbus_sram_array.sv
// Byte-strobed word array.
// One write port, one combinational read port.
module cbus_sram_array #(
  parameter int    DEPTH_LOG = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [DEPTH_LOG-1:0] waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic [DEPTH_LOG-1:0] raddr_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cbus_sram_responder.sv
// CBus responder backed by on-chip SRAM; define CBUS_SRAM_RANDOM_STALL_EN
// to insert pseudo-random backpressure in BURST.
module cbus_sram_responder
    import cbus_pkg::*;
    import cbus_sram_responder_pkg::*;
#(
    parameter int    DEPTH_LOG   = 10,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  req,
    output cbus_resp_t resp
);

    cbus_sram_state_t     state_q, state_d;
    logic [DEPTH_LOG-1:0] idx_q, idx_d;
    logic [DEPTH_LOG-1:0] idx_step;
    logic [DEPTH_LOG-1:0] wmask;
    logic [3:0]           len_q, len_d;
    logic [3:0]           beat_q, beat_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [1:0]           burst_q, burst_d;
    logic                 wr_q, wr_d;
    logic                 stall;
    logic                 rdy;
    logic                 accept;
    logic [31:0]          rdata;
    logic                 unused_req;

    assign unused_req = ^{req.size, req.addr[31:DEPTH_LOG+2], req.addr[1:0]};

`ifdef CBUS_SRAM_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // WRAP keeps the upper index bits and wraps the low log2(len+1) bits
    assign wmask = DEPTH_LOG'(len_q);

    always_comb begin
        idx_step = idx_q + 1'b1;
        unique case (burst_q)
            CBUS_BURST_FIXED: idx_step = idx_q;
            CBUS_BURST_WRAP: begin
                if (wrap_len_ok(len_q)) begin
                    idx_step = (idx_q & ~wmask) | ((idx_q + 1'b1) & wmask);
                end
            end
            default: idx_step = idx_q + 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        wr_d    = wr_q;
        rdy     = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req.valid) begin
                    idx_d   = req.addr[2 +: DEPTH_LOG];
                    len_d   = req.len;
                    burst_d = req.burst;
                    wr_d    = req.is_write;
                    beat_d  = 4'd0;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!req.valid) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                rdy = !stall;
                if (!req.valid) begin
                    state_d = IDLE;
                end else if (rdy) begin
                    accept = 1'b1;
                    idx_d  = idx_step;
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            burst_q <= CBUS_BURST_FIXED;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            wr_q    <= wr_d;
        end
    end

    cbus_sram_array #(
        .DEPTH_LOG (DEPTH_LOG),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk_i   (clk),
        .we_i    (accept && wr_q),
        .be_i    (req.strobe),
        .waddr_i (idx_q),
        .wdata_i (req.data),
        .raddr_i (idx_q),
        .rdata_o (rdata)
    );

    assign resp.ready = rdy;
    assign resp.last  = rdy && (beat_q == len_q);
    assign resp.data  = (rdy && !wr_q) ? rdata : 32'd0;

endmodule
